locst_bist_ctrl: RTL and testbench

//  Parametrised LOC scan-BIST sequencer with on-chip signature check.

---
 rtl/locst_bist_ctrl_if.sv | 39 +++
 rtl/locst_bist_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_locst_bist_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/locst_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : locst_bist_ctrl_if
//  Description : Test-port and SRSG/SISR chain signals of the LOC scan-BIST
//                sequencer, with master (test port) and slave (sequencer) views.
//  Revision    : 1.0  initial release
// ============================================================================
interface locst_bist_ctrl_if #(
  parameter int SIG_W   = 16,
  parameter int SHIFT_W = 8,
  parameter int PAT_W   = 16
);
  logic               start;
  logic               abort;
  logic [SHIFT_W-1:0] cfg_shift_len;
  logic [PAT_W-1:0]   cfg_num_pat;
  logic [SIG_W-1:0]   golden_sig;
  logic [SIG_W-1:0]   sisr_sig;
  logic               NbarT;
  logic               cut_rst;
  logic               srsg_en;
  logic               sisr_en;
  logic               busy;
  logic               done;
  logic               pass;
  logic               fail;
  logic [PAT_W-1:0]   pat_cnt;

  modport master (
    output start, abort, cfg_shift_len, cfg_num_pat, golden_sig, sisr_sig,
    input  NbarT, cut_rst, srsg_en, sisr_en, busy, done, pass, fail, pat_cnt
  );

  modport slave (
    input  start, abort, cfg_shift_len, cfg_num_pat, golden_sig, sisr_sig,
    output NbarT, cut_rst, srsg_en, sisr_en, busy, done, pass, fail, pat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/locst_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : locst_bist_ctrl
//  Description : LOC scan-BIST sequencer: init, shift, launch/capture and
//                unload phases with an on-chip SISR signature compare.
//  Revision    : 1.0  initial release
// ============================================================================
module locst_bist_ctrl #(
  parameter int SIG_W    = 16,
  parameter int SHIFT_W  = 8,
  parameter int PAT_W    = 16,
  parameter int CAP_CYC  = 2,
  parameter int INIT_CYC = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  locst_bist_ctrl_if.slave bus
);

  localparam int c_cnt_base = (SHIFT_W > 3) ? SHIFT_W : 3;
  localparam int c_init_w   = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int c_cnt_w    = (c_init_w > c_cnt_base) ? c_init_w : c_cnt_base;

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_init_ld  = c_cnt_w'(INIT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cap_ld   = c_cnt_w'(CAP_CYC - 1);
  localparam logic [SHIFT_W-1:0] c_len_one  = SHIFT_W'(1);
  localparam logic [PAT_W-1:0]   c_pat_one  = PAT_W'(1);
  localparam logic [PAT_W:0]     c_inc_one  = (PAT_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SHIFT  = 3'd2,
    S_CAP    = 3'd3,
    S_UNLOAD = 3'd4,
    S_CMP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               r_state;
  logic [SHIFT_W-1:0]   r_shift_len;
  logic [PAT_W-1:0]     r_num_pat;
  logic [c_cnt_w-1:0]   r_phase;
  logic [PAT_W-1:0]     r_pat_cnt;
  logic                 r_nbart;
  logic                 r_cut_rst;
  logic                 r_srsg_en;
  logic                 r_sisr_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_fail;

  logic                 w_phase_end;
  logic [PAT_W:0]       w_pat_inc;
  logic                 w_last_pat;
  logic [c_cnt_w-1:0]   w_shift_ld;
  logic                 w_sig_match;

  assign w_phase_end = (r_phase == '0);
  assign w_pat_inc   = {1'b0, r_pat_cnt} + c_inc_one;
  assign w_last_pat  = (w_pat_inc == {1'b0, r_num_pat});
  assign w_shift_ld  = c_cnt_w'(r_shift_len) - c_cnt_one;
  assign w_sig_match = (bus.sisr_sig == bus.golden_sig);

  // Outputs are set together with the state they belong to, so every
  // output is a flop and changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift_len <= c_len_one;
      r_num_pat   <= c_pat_one;
      r_phase     <= '0;
      r_pat_cnt   <= '0;
      r_nbart     <= 1'b0;
      r_cut_rst   <= 1'b1;
      r_srsg_en   <= 1'b0;
      r_sisr_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && bus.abort) begin
        r_state   <= S_IDLE;
        r_nbart   <= 1'b0;
        r_cut_rst <= 1'b0;
        r_srsg_en <= 1'b0;
        r_sisr_en <= 1'b0;
        r_busy    <= 1'b0;
        r_pass    <= 1'b0;
        r_fail    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cut_rst <= 1'b0;
            r_nbart   <= 1'b0;
            r_srsg_en <= 1'b0;
            r_sisr_en <= 1'b0;
            if (bus.start) begin
              r_state     <= S_INIT;
              // A zero length or count would never terminate; run it as one.
              r_shift_len <= (bus.cfg_shift_len == '0) ? c_len_one : bus.cfg_shift_len;
              r_num_pat   <= (bus.cfg_num_pat == '0) ? c_pat_one : bus.cfg_num_pat;
              r_pat_cnt   <= '0;
              r_pass      <= 1'b0;
              r_fail      <= 1'b0;
              r_cut_rst   <= 1'b1;
              r_busy      <= 1'b1;
              r_phase     <= c_init_ld;
            end
          end
          S_INIT: begin
            if (w_phase_end) begin
              r_state   <= S_SHIFT;
              r_cut_rst <= 1'b0;
              r_nbart   <= 1'b1;
              r_srsg_en <= 1'b1;
              r_sisr_en <= 1'b1;
              r_phase   <= w_shift_ld;
            end else begin
              r_phase <= r_phase - c_cnt_one;
            end
          end
          S_SHIFT: begin
            if (w_phase_end) begin
              r_state   <= S_CAP;
              r_nbart   <= 1'b0;
              r_srsg_en <= 1'b0;
              r_sisr_en <= 1'b0;
              r_phase   <= c_cap_ld;
            end else begin
              r_phase <= r_phase - c_cnt_one;
            end
          end
          S_CAP: begin
            if (w_phase_end) begin
              r_pat_cnt <= (&r_pat_cnt) ? r_pat_cnt : w_pat_inc[PAT_W-1:0];
              r_state   <= w_last_pat ? S_UNLOAD : S_SHIFT;
              r_nbart   <= 1'b1;
              r_srsg_en <= 1'b1;
              r_sisr_en <= 1'b1;
              r_phase   <= w_shift_ld;
            end else begin
              r_phase <= r_phase - c_cnt_one;
            end
          end
          S_UNLOAD: begin
            if (w_phase_end) begin
              r_state   <= S_CMP;
              r_nbart   <= 1'b0;
              r_srsg_en <= 1'b0;
              r_sisr_en <= 1'b0;
            end else begin
              r_phase <= r_phase - c_cnt_one;
            end
          end
          S_CMP: begin
            r_state <= S_DONE;
            r_pass  <= w_sig_match;
            r_fail  <= ~w_sig_match;
            r_done  <= 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state   <= S_IDLE;
            r_nbart   <= 1'b0;
            r_cut_rst <= 1'b0;
            r_srsg_en <= 1'b0;
            r_sisr_en <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.NbarT   = r_nbart;
  assign bus.cut_rst = r_cut_rst;
  assign bus.srsg_en = r_srsg_en;
  assign bus.sisr_en = r_sisr_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.fail    = r_fail;
  assign bus.pat_cnt = r_pat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_locst_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_locst_bist_ctrl
//  Description : Self-checking bench for locst_bist_ctrl against a phase-
//                arithmetic reference model, plus directed literal scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_locst_bist_ctrl;

  localparam int SIG_W    = 16;
  localparam int SHIFT_W  = 8;
  localparam int PAT_W    = 16;
  localparam int CAP_CYC  = 2;
  localparam int INIT_CYC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  locst_bist_ctrl_if #(.SIG_W(SIG_W), .SHIFT_W(SHIFT_W), .PAT_W(PAT_W)) bus ();

  locst_bist_ctrl #(
    .SIG_W(SIG_W), .SHIFT_W(SHIFT_W), .PAT_W(PAT_W),
    .CAP_CYC(CAP_CYC), .INIT_CYC(INIT_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase of cycle k (1 = first cycle after start accept):
  // 0 idle, 1 init, 2 shift, 3 capture, 4 unload, 5 compare, 6 done.
  function automatic int phase_of(input int k, input int len, input int np);
    int t, seg, u;
    if (k <= INIT_CYC) return 1;
    t   = k - INIT_CYC - 1;
    seg = len + CAP_CYC;
    if (t < np * seg) return ((t % seg) < len) ? 2 : 3;
    u = t - np * seg;
    if (u < len)      return 4;
    if (u == len)     return 5;
    if (u == len + 1) return 6;
    return 0;
  endfunction

  function automatic int pat_of(input int k, input int len, input int np);
    int t, seg;
    if (k <= INIT_CYC) return 0;
    t   = k - INIT_CYC - 1;
    seg = len + CAP_CYC;
    return (t < np * seg) ? (t / seg) : np;
  endfunction

  function automatic int done_cycle(input int len, input int np);
    return INIT_CYC + np * (len + CAP_CYC) + len + 2;
  endfunction

  // Reference model state, advanced on every active clock edge.
  bit m_active = 1'b0;
  bit m_pass   = 1'b0;
  bit m_fail   = 1'b0;
  bit m_fresh  = 1'b1;
  int m_k      = 0;
  int m_len    = 1;
  int m_np     = 1;
  int m_pat    = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_pass   = 1'b0;
        m_fail   = 1'b0;
        m_pat    = 0;
        m_fresh  = 1'b1;
      end else begin
        m_fresh = 1'b0;
        if (!m_active) begin
          if (bus.start) begin
            m_active = 1'b1;
            m_k      = 1;
            m_len    = (bus.cfg_shift_len == 0) ? 1 : int'(bus.cfg_shift_len);
            m_np     = (bus.cfg_num_pat == 0) ? 1 : int'(bus.cfg_num_pat);
            m_pass   = 1'b0;
            m_fail   = 1'b0;
            m_pat    = 0;
          end
        end else if (bus.abort) begin
          m_pat    = pat_of(m_k, m_len, m_np);
          m_active = 1'b0;
          m_fail   = 1'b1;
          m_pass   = 1'b0;
        end else if (m_k == done_cycle(m_len, m_np)) begin
          m_active = 1'b0;
          m_pat    = m_np;
        end else begin
          if (phase_of(m_k, m_len, m_np) == 5) begin
            m_pass = (bus.sisr_sig == bus.golden_sig);
            m_fail = !m_pass;
          end
          m_k++;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    int ph;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_nbart",   32'(bus.NbarT),   32'(0));
        chk("rst_cut_rst", 32'(bus.cut_rst), 32'(1));
        chk("rst_srsg_en", 32'(bus.srsg_en), 32'(0));
        chk("rst_sisr_en", 32'(bus.sisr_en), 32'(0));
        chk("rst_busy",    32'(bus.busy),    32'(0));
        chk("rst_done",    32'(bus.done),    32'(0));
        chk("rst_pass",    32'(bus.pass),    32'(0));
        chk("rst_fail",    32'(bus.fail),    32'(0));
        chk("rst_pat_cnt", 32'(bus.pat_cnt), 32'(0));
      end else begin
        ph = m_active ? phase_of(m_k, m_len, m_np) : 0;
        chk("nbart",   32'(bus.NbarT),   32'(ph == 2 || ph == 4));
        chk("cut_rst", 32'(bus.cut_rst), 32'(m_active ? (ph == 1) : m_fresh));
        chk("srsg_en", 32'(bus.srsg_en), 32'(ph == 2 || ph == 4));
        chk("sisr_en", 32'(bus.sisr_en), 32'(ph == 2 || ph == 4));
        chk("busy",    32'(bus.busy),    32'(m_active));
        chk("done",    32'(bus.done),    32'(ph == 6));
        chk("pass",    32'(bus.pass),    32'(m_pass));
        chk("fail",    32'(bus.fail),    32'(m_fail));
        chk("pat_cnt", 32'(bus.pat_cnt), 32'(m_active ? pat_of(m_k, m_len, m_np) : m_pat));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input int len, input int np, input logic [15:0] g, input logic [15:0] s);
    bus.cfg_shift_len = SHIFT_W'(len);
    bus.cfg_num_pat   = PAT_W'(np);
    bus.golden_sig    = g;
    bus.sisr_sig      = s;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
  endtask

  // From cycle c0 onwards, wait for done; returns its cycle and NbarT-high count.
  task automatic wait_done(input int c0, input int limit, output int c, output int nb);
    c  = c0;
    nb = 0;
    while (!bus.done && c < limit) begin
      if (bus.NbarT) nb++;
      tick();
      c++;
    end
  endtask

  initial begin
    int c, nb, dn;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_shift_len = '0; bus.cfg_num_pat = '0;
    bus.golden_sig = '0; bus.sisr_sig = '0;

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("lit_rst_cut_rst", 32'(bus.cut_rst), 32'(1));
    chk("lit_rst_busy",    32'(bus.busy),    32'(0));
    rst_n = 1'b1;
    tick();
    chk("lit_post_rst_cut_rst", 32'(bus.cut_rst), 32'(0));

    // T1: matching signature
    start_run(24, 3, 16'hBEEF, 16'hBEEF);
    wait_done(1, 300, c, nb);
    chk("t1_done_cyc", c, 106);
    chk("t1_pass",     32'(bus.pass),    32'(1));
    chk("t1_fail",     32'(bus.fail),    32'(0));
    chk("t1_pat_cnt",  32'(bus.pat_cnt), 32'(3));
    chk("t1_nbart_cyc", nb, 96);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'(0));
    chk("t1_pass_sticky", 32'(bus.pass), 32'(1));

    // T2: mismatching signature
    start_run(24, 3, 16'hBEEF, 16'hBEEE);
    wait_done(1, 300, c, nb);
    chk("t2_done_cyc", c, 106);
    chk("t2_pass", 32'(bus.pass), 32'(0));
    chk("t2_fail", 32'(bus.fail), 32'(1));
    tick();

    // T3: abort during cycle 40
    start_run(24, 3, 16'hBEEF, 16'hBEEF);
    repeat (39) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t3_busy",    32'(bus.busy),    32'(0));
    chk("t3_nbart",   32'(bus.NbarT),   32'(0));
    chk("t3_fail",    32'(bus.fail),    32'(1));
    chk("t3_pass",    32'(bus.pass),    32'(0));
    chk("t3_pat_cnt", 32'(bus.pat_cnt), 32'(1));
    dn = 0;
    repeat (10) begin
      if (bus.done) dn++;
      tick();
    end
    chk("t3_no_done", dn, 0);

    // T4: zero config treated as 1/1
    start_run(0, 0, 16'h1234, 16'h1234);
    wait_done(1, 100, c, nb);
    chk("t4_done_cyc", c, 8);
    chk("t4_pat_cnt", 32'(bus.pat_cnt), 32'(1));
    tick();

    // T5: start re-asserted mid-run with a different config
    start_run(24, 3, 16'hBEEF, 16'hBEEF);
    repeat (9) tick();
    bus.cfg_shift_len = 8'd5;
    bus.cfg_num_pat   = 16'd1;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
    wait_done(11, 300, c, nb);
    chk("t5_done_cyc", c, 106);
    chk("t5_nbart_cyc", nb, 88);
    chk("t5_pat_cnt", 32'(bus.pat_cnt), 32'(3));
    tick();

    // T6: reset mid-run, then a clean rerun
    start_run(24, 3, 16'hBEEF, 16'hBEEF);
    repeat (29) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_cut_rst", 32'(bus.cut_rst), 32'(1));
    chk("t6_async_nbart",   32'(bus.NbarT),   32'(0));
    chk("t6_async_busy",    32'(bus.busy),    32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_run(24, 3, 16'hBEEF, 16'hBEEF);
    wait_done(1, 300, c, nb);
    chk("t6_done_cyc", c, 106);
    chk("t6_pass", 32'(bus.pass), 32'(1));
    tick();

    // Randomized traffic: starts, aborts, config changes and rare resets
    for (int i = 0; i < 3000; i++) begin
      bus.start         = ($urandom % 6) == 0;
      bus.abort         = ($urandom % 80) == 0;
      bus.cfg_shift_len = SHIFT_W'($urandom % 12);
      bus.cfg_num_pat   = PAT_W'($urandom % 4);
      bus.golden_sig    = SIG_W'($urandom);
      bus.sisr_sig      = (($urandom % 2) == 0) ? bus.golden_sig : SIG_W'($urandom);
      rst_n             = ($urandom % 700) != 0;
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
